// File: rtl/int_issue_arbiter.sv
// Two-requester round-robin arbiter feeding one shared execution unit through a one-entry
// hold register, with multicycle occupancy tracking and robid-based flush kill.
`ifndef ISQ_DATA_WIDTH
`define ISQ_DATA_WIDTH 16
`endif
`ifndef INSTR_ID_WIDTH
`define INSTR_ID_WIDTH 4
`endif

module int_issue_arbiter #(
   parameter int unsigned MC_LATENCY = 4
) (
   input  logic                         clock,
   input  logic                         reset,
   input  logic [`ISQ_DATA_WIDTH-1:0]   req0_data,
   input  logic [`INSTR_ID_WIDTH:0]     req0_robid,
   input  logic                         req0_multicycle,
   input  logic                         req0_valid,
   output logic                         req0_ready,
   input  logic [`ISQ_DATA_WIDTH-1:0]   req1_data,
   input  logic [`INSTR_ID_WIDTH:0]     req1_robid,
   input  logic                         req1_multicycle,
   input  logic                         req1_valid,
   output logic                         req1_ready,
   output logic [`ISQ_DATA_WIDTH-1:0]   issue_data,
   output logic [`INSTR_ID_WIDTH:0]     issue_robid,
   output logic                         issue_src,
   output logic                         issue_valid,
   input  logic                         issue_ready,
   input  logic                         flush_valid,
   input  logic [`INSTR_ID_WIDTH:0]     flush_robid,
   output logic                         exu_busy
);

   localparam int unsigned DW   = `ISQ_DATA_WIDTH;
   localparam int unsigned IW   = `INSTR_ID_WIDTH + 1;
   localparam int unsigned CntW = (MC_LATENCY > 2) ? $clog2(MC_LATENCY) : 1;

   typedef enum logic [1:0] {StIdle, StHold, StBusy} state_e;

   state_e            state_q, state_d;
   logic [DW-1:0]     data_q, data_d;
   logic [IW-1:0]     robid_q, robid_d;
   logic              src_q, src_d;
   logic              mc_q, mc_d;
   logic              rr_q, rr_d;
   logic [CntW-1:0]   cnt_q, cnt_d;

   logic kill, handshake, accept_ok, accept, gnt, any_valid;

   // Wrap bit flips the sense of the low-order comparison; equal ids are not younger.
   function automatic logic younger(input logic [IW-1:0] a, input logic [IW-1:0] b);
      if (a[IW-1] == b[IW-1]) return a[IW-2:0] > b[IW-2:0];
      else                    return a[IW-2:0] < b[IW-2:0];
   endfunction

   always_comb begin
      kill      = (state_q == StHold) && flush_valid && younger(robid_q, flush_robid);
      issue_valid = (state_q == StHold) && !kill && !reset;
      handshake = issue_valid && issue_ready;
      exu_busy  = (state_q == StBusy) && !reset;

      any_valid = req0_valid || req1_valid;
      if (req0_valid && req1_valid) gnt = rr_q;
      else                          gnt = !req0_valid;

      accept_ok = ((state_q == StIdle) || (handshake && !mc_q)) && !flush_valid && !reset;
      accept    = accept_ok && any_valid;
      req0_ready = accept && !gnt;
      req1_ready = accept && gnt;
   end

   assign issue_data  = data_q;
   assign issue_robid = robid_q;
   assign issue_src   = src_q;

   always_comb begin
      state_d = state_q;
      data_d  = data_q;
      robid_d = robid_q;
      src_d   = src_q;
      mc_d    = mc_q;
      rr_d    = rr_q;
      cnt_d   = cnt_q;

      if (accept) begin
         rr_d    = !gnt;
         state_d = StHold;
         src_d   = gnt;
         data_d  = gnt ? req1_data       : req0_data;
         robid_d = gnt ? req1_robid      : req0_robid;
         mc_d    = gnt ? req1_multicycle : req0_multicycle;
      end

      unique case (state_q)
         StIdle: ;
         StHold: begin
            if (kill) begin
               state_d = StIdle;
            end else if (handshake) begin
               if (mc_q) begin
                  state_d = StBusy;
                  cnt_d   = CntW'(MC_LATENCY - 1);
               end else if (!accept) begin
                  state_d = StIdle;
               end
            end
         end
         StBusy: begin
            if (cnt_q == '0) state_d = StIdle;
            else             cnt_d   = cnt_q - 1'b1;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= StIdle;
         data_q  <= '0;
         robid_q <= '0;
         src_q   <= 1'b0;
         mc_q    <= 1'b0;
         rr_q    <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         data_q  <= data_d;
         robid_q <= robid_d;
         src_q   <= src_d;
         mc_q    <= mc_d;
         rr_q    <= rr_d;
         cnt_q   <= cnt_d;
      end
   end

endmodule

// File: tb/tb_int_issue_arbiter.sv
// Directed self-checking bench for int_issue_arbiter: arbitration, hold, multicycle, flush, reset.
`ifndef ISQ_DATA_WIDTH
`define ISQ_DATA_WIDTH 16
`endif
`ifndef INSTR_ID_WIDTH
`define INSTR_ID_WIDTH 4
`endif

module tb_int_issue_arbiter;

   localparam int unsigned DW = `ISQ_DATA_WIDTH;
   localparam int unsigned IW = `INSTR_ID_WIDTH + 1;

   logic          clock = 1'b0;
   logic          reset;
   logic [DW-1:0] req0_data, req1_data, issue_data;
   logic [IW-1:0] req0_robid, req1_robid, issue_robid, flush_robid;
   logic          req0_multicycle, req1_multicycle, req0_valid, req1_valid;
   logic          req0_ready, req1_ready, issue_src, issue_valid, issue_ready;
   logic          flush_valid, exu_busy;

   int checks = 0;
   int errors = 0;

   int_issue_arbiter #(.MC_LATENCY(4)) dut (
      .clock           (clock),
      .reset           (reset),
      .req0_data       (req0_data),
      .req0_robid      (req0_robid),
      .req0_multicycle (req0_multicycle),
      .req0_valid      (req0_valid),
      .req0_ready      (req0_ready),
      .req1_data       (req1_data),
      .req1_robid      (req1_robid),
      .req1_multicycle (req1_multicycle),
      .req1_valid      (req1_valid),
      .req1_ready      (req1_ready),
      .issue_data      (issue_data),
      .issue_robid     (issue_robid),
      .issue_src       (issue_src),
      .issue_valid     (issue_valid),
      .issue_ready     (issue_ready),
      .flush_valid     (flush_valid),
      .flush_robid     (flush_robid),
      .exu_busy        (exu_busy)
   );

   always #5 clock = ~clock;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, required finish before 200000");
      $fatal(1, "timeout");
   end

   // Advance to 1 time unit after the next rising edge; inputs are driven here.
   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic idle_inputs();
      req0_valid = 0; req1_valid = 0; req0_multicycle = 0; req1_multicycle = 0;
      req0_data = '0; req1_data = '0; req0_robid = '0; req1_robid = '0;
      issue_ready = 0; flush_valid = 0; flush_robid = '0;
   endtask

   task automatic test_reset();
      idle_inputs();
      reset = 1;
      req0_valid = 1;
      tick();
      tick();
      settle();
      checks++; if (req0_ready !== 1'b0) begin errors++;
         $display("FAIL reset_ready0: got %b required 0", req0_ready); end
      checks++; if (issue_valid !== 1'b0) begin errors++;
         $display("FAIL reset_issue_valid: got %b required 0", issue_valid); end
      checks++; if (exu_busy !== 1'b0) begin errors++;
         $display("FAIL reset_exu_busy: got %b required 0", exu_busy); end
      checks++; if (issue_robid !== 5'd0 || issue_data !== 16'd0) begin errors++;
         $display("FAIL reset_held: got robid %0h data %0h required 0 0", issue_robid, issue_data);
      end
      req0_valid = 0;
      reset = 0;
      tick();
   endtask

   task automatic test_back_to_back();
      // rr=0 after reset: req0 first, then req1 back to back.
      req0_valid = 1; req0_data = 16'hA0A0; req0_robid = 5'd5;
      req1_valid = 1; req1_data = 16'hB1B1; req1_robid = 5'd6;
      issue_ready = 1;
      settle();
      checks++; if ({req0_ready, req1_ready} !== 2'b10) begin errors++;
         $display("FAIL b2b_grant0: got %b required 10", {req0_ready, req1_ready}); end
      tick();
      req0_valid = 0;
      settle();
      checks++; if ({issue_valid, issue_src, issue_data, issue_robid} !== {1'b1, 1'b0, 16'hA0A0, 5'd5})
         begin errors++;
         $display("FAIL b2b_issue0: got v%b s%b %0h %0d required v1 s0 a0a0 5",
                  issue_valid, issue_src, issue_data, issue_robid); end
      checks++; if ({req0_ready, req1_ready} !== 2'b01) begin errors++;
         $display("FAIL b2b_grant1: got %b required 01", {req0_ready, req1_ready}); end
      tick();
      req1_valid = 0;
      settle();
      checks++; if ({issue_valid, issue_src, issue_data, issue_robid} !== {1'b1, 1'b1, 16'hB1B1, 5'd6})
         begin errors++;
         $display("FAIL b2b_issue1: got v%b s%b %0h %0d required v1 s1 b1b1 6",
                  issue_valid, issue_src, issue_data, issue_robid); end
      tick();
      settle();
      checks++; if (issue_valid !== 1'b0) begin errors++;
         $display("FAIL b2b_idle: got %b required 0", issue_valid); end
      issue_ready = 0;
   endtask

   task automatic test_hold_and_rr();
      // rr is 0 again (req0 then req1 granted above).
      req0_valid = 1; req0_data = 16'h1111; req0_robid = 5'd8;
      req1_valid = 1; req1_data = 16'h2222; req1_robid = 5'd9;
      settle();
      checks++; if ({req0_ready, req1_ready} !== 2'b10) begin errors++;
         $display("FAIL rr_first: got %b required 10", {req0_ready, req1_ready}); end
      tick();
      req0_data = 16'h3333; req0_robid = 5'd10;
      for (int i = 0; i < 3; i++) begin
         settle();
         checks++; if ({issue_valid, issue_data, issue_robid, req0_ready, req1_ready} !==
                       {1'b1, 16'h1111, 5'd8, 2'b00}) begin errors++;
            $display("FAIL hold_stall%0d: got v%b %0h %0d rdy %b%b required v1 1111 8 rdy 00",
                     i, issue_valid, issue_data, issue_robid, req0_ready, req1_ready); end
         tick();
      end
      issue_ready = 1;
      settle();
      checks++; if ({req0_ready, req1_ready} !== 2'b01) begin errors++;
         $display("FAIL rr_toggle: got %b required 01", {req0_ready, req1_ready}); end
      tick();
      req1_valid = 0;
      settle();
      checks++; if ({issue_src, issue_data, req0_ready} !== {1'b1, 16'h2222, 1'b1}) begin errors++;
         $display("FAIL rr_third: got s%b %0h r0 %b required s1 2222 r0 1",
                  issue_src, issue_data, req0_ready); end
      tick();
      req0_valid = 0;
      settle();
      checks++; if ({issue_src, issue_data, issue_robid} !== {1'b0, 16'h3333, 5'd10}) begin errors++;
         $display("FAIL rr_third_issue: got s%b %0h %0d required s0 3333 10",
                  issue_src, issue_data, issue_robid); end
      tick();
      issue_ready = 0;
   endtask

   task automatic test_multicycle();
      req1_valid = 1; req1_multicycle = 1; req1_data = 16'hCAFE; req1_robid = 5'd7;
      issue_ready = 1;
      settle();
      checks++; if (req1_ready !== 1'b1) begin errors++;
         $display("FAIL mc_accept: got %b required 1", req1_ready); end
      tick();
      req1_valid = 0; req1_multicycle = 0;
      req0_valid = 1; req0_data = 16'h4444; req0_robid = 5'd11;
      settle();
      checks++; if ({issue_valid, exu_busy, req0_ready} !== 3'b100) begin errors++;
         $display("FAIL mc_hold: got v%b b%b r0 %b required v1 b0 r0 0",
                  issue_valid, exu_busy, req0_ready); end
      tick();
      for (int i = 0; i < 4; i++) begin
         flush_valid = (i == 1);
         flush_robid = 5'd0;
         settle();
         checks++; if ({exu_busy, issue_valid, req0_ready, req1_ready} !== 4'b1000) begin errors++;
            $display("FAIL mc_busy%0d: got b%b v%b rdy %b%b required b1 v0 rdy 00",
                     i, exu_busy, issue_valid, req0_ready, req1_ready); end
         tick();
      end
      flush_valid = 0;
      settle();
      checks++; if ({exu_busy, req0_ready} !== 2'b01) begin errors++;
         $display("FAIL mc_done: got b%b r0 %b required b0 r0 1", exu_busy, req0_ready); end
      tick();
      req0_valid = 0;
      tick();
      issue_ready = 0;
   endtask

   task automatic test_flush();
      req0_valid = 1; req0_data = 16'h5555; req0_robid = 5'b1_0010;
      tick();
      req0_valid = 0;
      flush_valid = 1; flush_robid = 5'b0_1110; issue_ready = 1;
      settle();
      checks++; if (issue_valid !== 1'b0) begin errors++;
         $display("FAIL flush_kill: got %b required 0", issue_valid); end
      tick();
      flush_valid = 0; issue_ready = 0;
      settle();
      checks++; if (issue_valid !== 1'b0) begin errors++;
         $display("FAIL flush_idle: got %b required 0", issue_valid); end
      req0_valid = 1;
      tick();
      req0_valid = 0;
      flush_valid = 1; flush_robid = 5'b1_0010;
      settle();
      checks++; if ({issue_valid, issue_robid} !== {1'b1, 5'b1_0010}) begin errors++;
         $display("FAIL flush_equal: got v%b %b required v1 10010", issue_valid, issue_robid); end
      tick();
      flush_robid = 5'b1_0011;
      settle();
      checks++; if ({issue_valid, issue_data} !== {1'b1, 16'h5555}) begin errors++;
         $display("FAIL flush_older: got v%b %0h required v1 5555", issue_valid, issue_data); end
      flush_robid = 5'b1_0001;
      settle();
      checks++; if (issue_valid !== 1'b0) begin errors++;
         $display("FAIL flush_same_wrap: got %b required 0", issue_valid); end
      tick();
      flush_valid = 0;
      settle();
      checks++; if (issue_valid !== 1'b0) begin errors++;
         $display("FAIL flush_same_wrap_idle: got %b required 0", issue_valid); end
   endtask

   task automatic test_reset_busy();
      // req0 multicycle grant leaves rr=1 before reset.
      req0_valid = 1; req0_multicycle = 1; req0_data = 16'h6666; req0_robid = 5'd3;
      issue_ready = 1;
      tick();
      req0_valid = 0; req0_multicycle = 0;
      tick();
      tick();
      settle();
      checks++; if (exu_busy !== 1'b1) begin errors++;
         $display("FAIL rstb_busy: got %b required 1", exu_busy); end
      reset = 1;
      settle();
      checks++; if (exu_busy !== 1'b0) begin errors++;
         $display("FAIL rstb_cycle: got %b required 0", exu_busy); end
      tick();
      reset = 0;
      req0_valid = 1; req1_valid = 1; issue_ready = 0;
      settle();
      checks++; if ({exu_busy, issue_valid, req0_ready, req1_ready} !== 4'b0010) begin errors++;
         $display("FAIL rstb_after: got b%b v%b rdy %b%b required b0 v0 rdy 10",
                  exu_busy, issue_valid, req0_ready, req1_ready); end
      tick();
      req0_valid = 0; req1_valid = 0;
      reset = 1;
      tick();
      reset = 0;
      settle();
      checks++; if (issue_valid !== 1'b0) begin errors++;
         $display("FAIL rst_hold: got %b required 0", issue_valid); end
   endtask

   initial begin
      test_reset();
      test_back_to_back();
      test_hold_and_rr();
      test_multicycle();
      test_flush();
      test_reset_busy();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/int_issue_arbiter.md
INT_ISSUE_ARBITER -- requirements
Module: int_issue_arbiter

Interface
REQ-001 Parameter MC_LATENCY, default 4 (legal >=2): cycles the shared execution unit stays occupied after a multicycle op issues.
REQ-002 clock  input  1  sole clock; all state updates on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 req0_data / req1_data  input  `ISQ_DATA_WIDTH  issue-queue payload from requester 0 / 1.
REQ-005 req0_robid / req1_robid  input  `INSTR_ID_WIDTH+1  ROB id; MSB is the wrap bit.
REQ-006 req0_multicycle / req1_multicycle  input  1  op occupies the unit MC_LATENCY cycles.
REQ-007 req0_valid / req1_valid  input  1  requester has an op.
REQ-008 req0_ready / req1_ready  output  1  arbiter accepts the op this cycle.
REQ-009 issue_data  output  `ISQ_DATA_WIDTH  held payload to the execution unit.
REQ-010 issue_robid  output  `INSTR_ID_WIDTH+1  held ROB id.
REQ-011 issue_src  output  1  requester index of held op.
REQ-012 issue_valid  output  1  held op offered to the unit.
REQ-013 issue_ready  input  1  unit takes the op.
REQ-014 flush_valid  input  1  pipeline flush.
REQ-015 flush_robid  input  `INSTR_ID_WIDTH+1  flush point; strictly younger ops are killed.
REQ-016 exu_busy  output  1  unit occupied by a multicycle op.

Function
REQ-017 FSM states IDLE, HOLD, BUSY; HOLD owns a one-entry register (data, robid, src, multicycle).
REQ-018 Accept condition: (IDLE, or HOLD with issue_ready=1, issue_valid=1, held multicycle=0) and flush_valid=0.
REQ-019 Only the granted requester sees ready=1 when accept condition holds; the other's ready SHALL be 0.
REQ-020 Grant: only one valid -> that one; both valid -> round-robin pointer rr; none -> no grant.
REQ-021 rr toggles to the non-granted index after each completed req handshake; unchanged otherwise.
REQ-022 Accepted op appears on issue_* the next cycle (latency 1); state -> HOLD.
REQ-023 HOLD: issue_* SHALL stay stable until handshake or kill.
REQ-024 HOLD handshake, held multicycle=0: new accept in same cycle -> stay HOLD with new op (back-to-back, 1 op/cycle); else -> IDLE.
REQ-025 HOLD handshake, held multicycle=1: -> BUSY, counter loaded MC_LATENCY-1; no accept that cycle.
REQ-026 BUSY: exu_busy=1, issue_valid=0, both readies 0; counter decrements each cycle; at counter==0 -> IDLE next cycle.
REQ-027 Younger(a,b): wrap bits equal -> a[low]>b[low]; wrap bits differ -> a[low]<b[low]; equal ids not younger.
REQ-028 issue_valid = HOLD and not (flush_valid and younger(held robid, flush_robid)), combinational.
REQ-029 Killed held op SHALL be dropped, no handshake; state -> IDLE; flush beats simultaneous issue_ready.
REQ-030 Flush with held op not younger: no effect on held op.
REQ-031 Flush in BUSY: counter continues; unit stays occupied.
REQ-032 Requesters SHALL keep payload stable while valid and not ready; the arbiter relies on this and does not check it.

Reset
REQ-033 Reset: state IDLE, rr=0, counter 0, held register 0; issue_valid=0, exu_busy=0, req0_ready=req1_ready=0 in the reset cycle.
REQ-034 Reset mid-HOLD or mid-BUSY SHALL discard the held op and counter with no issue handshake.

Verification
REQ-035 Both valid, robid 5 and 6, issue_ready=1 -> req0 accepted cycle 0, issue_src=0 cycle 1; req1 accepted cycle 1, issue_src=1 cycle 2.
REQ-036 req1 multicycle, MC_LATENCY=4, issue_ready=1 -> issue_valid one cycle, exu_busy=1 for 4 cycles, then req ready returns.
REQ-037 HOLD robid 0b1_0010, flush_robid 0b0_1110 -> issue_valid=0 that cycle, IDLE next; flush_robid 0b1_0010 -> op kept.
REQ-038 HOLD, issue_ready=0 for 3 cycles -> issue_data/robid unchanged; readies 0.
REQ-039 Reset asserted in BUSY with counter 2 -> next cycle IDLE, exu_busy=0, rr=0.
